// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and helpers for the UART RX front end.
//   PRESCALE_W_DEF  default width of the prescale value and of edge_cnt
//   FRAME_BITS_DEF  default bits per frame (start + 8 data + parity + stop)
//   PRESC_8/16/32   the legal oversampling ratios
//   half_prescale   H = P/2, the mid-bit edge index
//   legal_prescale  maps any prescale request onto a legal ratio (else 8)
package uart_rx_pkg;

    localparam int PRESCALE_W_DEF = 6;
    localparam int FRAME_BITS_DEF = 11;

    localparam logic [PRESCALE_W_DEF-1:0] PRESC_8  = PRESCALE_W_DEF'(8);
    localparam logic [PRESCALE_W_DEF-1:0] PRESC_16 = PRESCALE_W_DEF'(16);
    localparam logic [PRESCALE_W_DEF-1:0] PRESC_32 = PRESCALE_W_DEF'(32);

    function automatic logic [PRESCALE_W_DEF-1:0] half_prescale(
        input logic [PRESCALE_W_DEF-1:0] p
    );
        return p >> 1;
    endfunction

    function automatic logic [PRESCALE_W_DEF-1:0] legal_prescale(
        input logic [PRESCALE_W_DEF-1:0] p
    );
        case (p)
            PRESC_8, PRESC_16, PRESC_32: return p;
            default:                     return PRESC_8;
        endcase
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// edge_bit_counter: latches the oversampling ratio on the enable rise and
// walks edge_cnt (0..P-1) and bit_cnt (0..FRAME_BITS-1) through a frame.
//   clk, rst      oversampling clock, async active-high reset
//   enable        frame enable from the RX FSM
//   prescale      requested ratio, sampled only on the enable rise
//   active        counting this cycle (enable held since a fresh rise)
//   prescale_eff  ratio in force this cycle
//   edge_cnt      edge index within the current bit
//   bit_cnt       bit index within the frame
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  active,
    output logic [PRESCALE_W-1:0] prescale_eff,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    logic [PRESCALE_W-1:0] p_q;
    logic                  enable_q;
    logic                  run_q;
    logic                  rise;
    logic                  edge_last;
    logic                  bit_last;

    // enable_q resets high so an enable still held across a reset is not
    // mistaken for a rise: the next frame needs a genuine 0->1 edge.
    assign rise         = enable & ~enable_q;
    assign active       = enable & (run_q | rise);
    // On the rise cycle the new ratio is used straight away.
    assign prescale_eff = rise ? PRESCALE_W'(legal_prescale(PRESCALE_W_DEF'(prescale))) : p_q;
    assign edge_last    = (edge_cnt == prescale_eff - PRESCALE_W'(1));
    assign bit_last     = (bit_cnt == 4'(FRAME_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q      <= PRESCALE_W'(PRESC_8);
            enable_q <= 1'b1;
            run_q    <= 1'b0;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            enable_q <= enable;
            run_q    <= active;
            if (rise)
                p_q <= prescale_eff;
            if (!active) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (edge_last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_last ? 4'd0 : bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_edge_bit_sampler.sv
// rx_edge_bit_sampler: samples the synchronised serial line around mid-bit
// and presents one decided bit per bit period to the RX checkers.
//   clk, rst     oversampling clock, async active-high reset
//   enable       high while a frame is being received
//   rx_in        serial line (idle 1), already synchronised to clk
//   prescale     oversampling ratio (8, 16, 32; anything else acts as 8)
//   sampled_bit  decided value of the current bit
//   done         one-cycle strobe, high while edge_cnt == H+1
//   edge_cnt     edge index within the current bit
//   bit_cnt      bit index within the frame
// Build option RX_MAJORITY_VOTE_EN: when defined, the bit is the majority of
// the samples at edges H-2, H-1 and H; otherwise only the H-1 sample is used.
module rx_edge_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  done,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    logic                  active;
    logic [PRESCALE_W-1:0] prescale_eff;
    logic [PRESCALE_W-1:0] half;
    logic                  at_s1;
    logic                  at_s2;
    logic                  s1;
    logic                  vote;

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .FRAME_BITS (FRAME_BITS)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .prescale     (prescale),
        .active       (active),
        .prescale_eff (prescale_eff),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt)
    );

    assign half  = PRESCALE_W'(half_prescale(PRESCALE_W_DEF'(prescale_eff)));
    assign at_s1 = active && (edge_cnt == half - PRESCALE_W'(1));
    // The third sample is rx_in itself at edge H: feeding it straight into
    // the vote keeps the output one cycle after the last sample.
    assign at_s2 = active && (edge_cnt == half);

`ifdef RX_MAJORITY_VOTE_EN
    logic at_s0;
    logic s0;

    assign at_s0 = active && (edge_cnt == half - PRESCALE_W'(2));
    assign vote  = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s0 <= 1'b1;
        else if (at_s0)
            s0 <= rx_in;
    end
`else
    assign vote = s1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1 <= 1'b1;
        else if (at_s1)
            s1 <= rx_in;
    end

    // sampled_bit holds across disabled periods; done is a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sampled_bit <= 1'b1;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (at_s2) begin
                sampled_bit <= vote;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Bench for rx_edge_bit_sampler: stimulus queues the expected bit, bit index
// and edge position of every done strobe; a monitor checks each strobe.
module tb_rx_edge_bit_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rx_in;
    logic [5:0] prescale;
    logic       sampled_bit;
    logic       done;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;

    typedef struct {
        logic       sb;
        logic [3:0] bc;
        logic [5:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    rx_edge_bit_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .sampled_bit (sampled_bit),
        .done        (done),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sampled_bit", int'(sampled_bit), int'(e.sb));
                chk("done_bit_cnt", int'(bit_cnt), int'(e.bc));
                chk("done_edge_cnt", int'(edge_cnt), int'(e.ec));
            end
        end
    end

    // One clock cycle of stimulus, inputs applied on the falling edge.
    task automatic step(input logic r);
        rx_in = r;
        @(negedge clk);
    endtask

    task automatic expect_bit(input logic sb, input int bc, input int ec);
        exp_t e;
        e.sb = sb;
        e.bc = 4'(bc);
        e.ec = 6'(ec);
        exp_q.push_back(e);
    endtask

    // Drive one whole bit of period p at constant level, queuing its result.
    task automatic send_bit(input logic v, input int p, input int bc);
        expect_bit(v, bc, p / 2 + 1);
        for (int i = 0; i < p; i++) step(v);
    endtask

    logic [10:0] frame;
    logic        glitch_exp;

    initial begin
        rst = 1'b1; enable = 1'b0; rx_in = 1'b1; prescale = 6'd8;
        @(negedge clk);
        chk("reset_edge_cnt", int'(edge_cnt), 0);
        chk("reset_bit_cnt", int'(bit_cnt), 0);
        chk("reset_sampled_bit", int'(sampled_bit), 1);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        step(1'b1);

        // P=8, one 0-bit: done at edge 5, then bit_cnt advances on the wrap.
        enable = 1'b1; prescale = 6'd8;
        send_bit(1'b0, 8, 0);
        chk("p8_wrap_edge_cnt", int'(edge_cnt), 0);
        chk("p8_wrap_bit_cnt", int'(bit_cnt), 1);
        enable = 1'b0;
        step(1'b1);
        chk("disable_edge_cnt", int'(edge_cnt), 0);
        chk("disable_bit_cnt", int'(bit_cnt), 0);
        chk("disable_holds_bit", int'(sampled_bit), 0);

        // P=16, 0-bit with a one-cycle glitch at edge 7 (the middle sample).
`ifdef RX_MAJORITY_VOTE_EN
        glitch_exp = 1'b0;
`else
        glitch_exp = 1'b1;
`endif
        enable = 1'b1; prescale = 6'd16;
        expect_bit(glitch_exp, 0, 9);
        for (int i = 0; i < 16; i++) step(i == 7);
        enable = 1'b0;
        step(1'b1);

        // Full frame at P=32: start 0, data 10100101, parity 0, stop 1.
        frame = 11'b0_10100101_0_1;
        n_done = 0;
        enable = 1'b1; prescale = 6'd32;
        for (int b = 0; b < 11; b++) send_bit(frame[10-b], 32, b);
        chk("frame_wrap_bit_cnt", int'(bit_cnt), 0);
        chk("frame_wrap_edge_cnt", int'(edge_cnt), 0);
        chk("frame_done_count", n_done, 11);
        enable = 1'b0;
        step(1'b1);

        // Mid-frame prescale change 8->16 is ignored until the next rise.
        enable = 1'b1; prescale = 6'd8;
        expect_bit(1'b1, 0, 5);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) prescale = 6'd16;
            step(1'b1);
        end
        send_bit(1'b0, 8, 1);
        send_bit(1'b1, 8, 2);
        enable = 1'b0;
        step(1'b1);

        // Illegal prescale 5 behaves as 8.
        enable = 1'b1; prescale = 6'd5;
        send_bit(1'b0, 8, 0);
        send_bit(1'b1, 8, 1);
        enable = 1'b0;
        step(1'b1);

        // enable dropped in the cycle where edge_cnt==H: no done, no update.
        enable = 1'b1; prescale = 6'd8;
        for (int i = 0; i < 4; i++) step(1'b0);
        enable = 1'b0;
        step(1'b0);
        chk("drop_done", int'(done), 0);
        chk("drop_edge_cnt", int'(edge_cnt), 0);
        chk("drop_bit_cnt", int'(bit_cnt), 0);
        chk("drop_sampled_bit", int'(sampled_bit), 1);
        step(1'b0);

        // Asynchronous reset mid-bit, then no counting without a fresh rise.
        enable = 1'b1; prescale = 6'd8;
        send_bit(1'b0, 8, 0);
        for (int i = 0; i < 3; i++) step(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_edge_cnt", int'(edge_cnt), 0);
        chk("arst_bit_cnt", int'(bit_cnt), 0);
        chk("arst_sampled_bit", int'(sampled_bit), 1);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b0);
        chk("post_rst_idle_edge_cnt", int'(edge_cnt), 0);
        chk("post_rst_idle_bit_cnt", int'(bit_cnt), 0);
        enable = 1'b0;
        step(1'b1);
        enable = 1'b1;
        send_bit(1'b0, 8, 0);
        enable = 1'b0;
        step(1'b1);
        step(1'b1);

        chk("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_edge_bit_sampler.md
Name: rx_edge_bit_sampler

Overview:
- Upstream stage of the UART RX stop/parity/start checkers.
- Counts oversampling clock edges within each bit, tracks the bit index within the frame, and majority-votes three mid-bit samples of the serial line.
- Produces the `sampled_bit`, `done` and `bit_cnt` signals consumed by the checkers.
- Enabled by the RX FSM for the duration of a frame.

Parameters:
- PRESCALE_W, 6, width of the prescale input and of edge_cnt.
- FRAME_BITS, 11, bits per frame (start + 8 data + parity + stop); bit_cnt wraps after FRAME_BITS-1.

Ports:
- clk  input  1  RX oversampling clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  from RX FSM; high while a frame is being received.
- rx_in  input  1  serial line, already synchronised to clk; idle level 1.
- prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- sampled_bit  output  1  voted value of the current bit.
- done  output  1  one-cycle strobe: sampled_bit updated for the current bit.
- edge_cnt  output  PRESCALE_W  edge index within the current bit, 0..P-1.
- bit_cnt  output  4  bit index within the frame, 0..FRAME_BITS-1.

Behaviour:
- Reset (rst=1, async): edge_cnt=0, bit_cnt=0, sampled_bit=1, done=0, internal sample regs=1, P=8.
- P = prescale latched on the enable 0->1 edge; held constant for the whole frame.
  - A prescale change mid-frame is ignored until the next enable rise.
  - Illegal prescale (<8 or not 8/16/32) latches as 8.
- enable=0: edge_cnt and bit_cnt cleared to 0 synchronously; done=0; sampled_bit holds its last value.
- enable=1, each clk:
  - edge_cnt increments.
  - At edge_cnt==P-1, edge_cnt wraps to 0 and bit_cnt increments.
  - At bit_cnt==FRAME_BITS-1 with edge_cnt==P-1, both wrap to 0.
- Sample points, with H = P/2: rx_in captured at edge_cnt==H-2, H-1 and H (s0, s1, s2).
- Vote: on the clk after edge_cnt==H, sampled_bit <= majority(s0,s1,s2) and done=1 for exactly that one cycle.
  - done is therefore high while edge_cnt==H+1.
  - Latency from the last sample to output is 1 cycle.
- Exactly one done per bit, P cycles apart; FRAME_BITS done strobes per full frame.
- enable falling in the same cycle a done would be generated: enable wins, no done, counters cleared.
- Reset asserted mid-frame: all outputs return to reset values immediately. The next frame starts only on a fresh enable rise.
- All arithmetic is unsigned, PRESCALE_W bits; H computed by a right shift of P.

Optional Feature:
- Macro RX_MAJORITY_VOTE_EN.
  - Defined: three-sample majority vote as above.
  - Undefined: only s1 (edge_cnt==H-1) is captured; sampled_bit <= s1 with done at the same cycle position (edge_cnt==H+1). s0/s2 registers are not built.

Decomposition:
- Package uart_rx_pkg:
  - FRAME_BITS default.
  - PRESCALE_W.
  - Constants PRESC_8/16/32.
  - Function half_prescale(P).
- Sub-module edge_bit_counter: holds the prescale latch, edge_cnt and bit_cnt, and the wrap logic.
- The top level adds the sample registers, voter and done generation.

Test Plan:
- Reset, then enable=1, prescale=8, rx_in=0 for 8 cycles -> done at edge_cnt=5, sampled_bit=0, bit_cnt=0 then 1 at the next wrap.
- prescale=16, rx_in glitch to 1 only at edge_cnt=7 of a 0-bit -> sampled_bit=0 with vote; 1 with RX_MAJORITY_VOTE_EN undefined.
- Full 11-bit frame 0_10100101_0_1 at prescale=32 -> 11 done strobes 32 cycles apart, bits match, bit_cnt wraps 10->0.
- prescale changed 8->16 mid-frame -> period stays 8 until enable toggles; prescale=5 -> behaves as 8.
- enable dropped at edge_cnt=H -> no done on the next cycle; edge_cnt=0, bit_cnt=0.
- rst pulsed asynchronously mid-bit -> outputs immediately 0/0/1/0; no done until a new enable rise.
